exe_stage_mc: RTL and testbench
===============================

// Module: exe_stage_mc
// PURPOSE
//  Parametrised execute stage with valid/ready handshakes on both sides and an EX/MEM output register.
//  Runs single-cycle ALU ops, plus an optional iterative shift-add multiplier (multi-cycle, stalls upstream).
//  Sits between the decode/register-read stage and the memory stage.
//  Successor of the fixed 16-bit execute pipe.
// PARAMETERS
//  ARQ   16  datapath width (>=4)
//  REGW  4   destination register address width
//  OPW   4   opcode width
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     reset, asynchronous, active-low
//  flush         in   1     sync flush: drop output entry and any op in flight
//  in_valid      in   1     upstream op valid
//  in_ready      out  1     stage can accept op this cycle
//  in_op         in   OPW   opcode (see BEHAVIOUR)
//  in_src1       in   ARQ   operand A
//  in_src2       in   ARQ   operand B / shift amount
//  in_src3       in   ARQ   store data, passed through
//  in_rd         in   REGW  destination register, passed through
//  in_wb_en      in   1     writeback enable, passed through
//  in_rd_mem     in   1     memory read request, passed through
//  in_wr_mem     in   1     memory write request, passed through
//  out_valid     out  1     EX/MEM register holds a result
//  out_ready     in   1     memory stage consumes result
//  out_result    out  ARQ   ALU/MUL result
//  out_src3      out  ARQ   registered in_src3
//  out_rd        out  REGW  registered in_rd
//  out_wb_en / out_rd_mem / out_wr_mem  out 1  registered controls
//  out_flags     out  3     {illegal, carry, zero}
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0, FSM=IDLE, in_ready=0 while asserted.
//  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 PASS (result=src2), 8 MUL.
//    Others are illegal: result=0, illegal=1, control outputs forced 0.
//  - ADD: carry = bit ARQ of the (ARQ+1)-bit sum. SUB: carry = borrow (src1<src2 unsigned).
//    Other ops: carry=0. Shifts use src2[$clog2(ARQ)-1:0]. zero = (result==0).
//    MUL: low ARQ bits of the unsigned product.
//  - Transfer: an op is accepted on an edge with in_valid && in_ready.
//    in_ready = (state==IDLE) && (!out_valid || out_ready) && rst.
//  - Single-cycle op: the result is written to the EX/MEM reg on the accepting edge.
//    out_valid=1 the next cycle, so latency is 1.
//  - FSM states: IDLE, BUSY, DONE.
//    IDLE -> BUSY on MUL accept: operands, controls and cnt=ARQ-1 are latched.
//    BUSY: one shift-add iteration per edge. BUSY -> DONE after the cnt==0 iteration (ARQ edges).
//    DONE -> IDLE when the output slot is free (!out_valid || out_ready). Result is written on that edge.
//    MUL latency is ARQ+1 edges from accept with a free output. in_ready=0 in BUSY and DONE.
//  - Output hold: while out_valid && !out_ready, every out_* stays stable.
//    out_valid drops on the consuming edge unless a new result is written on the same edge.
//  - Simultaneous consume + accept: allowed. A new single-cycle result replaces the old one, so out_valid stays 1.
//  - flush (highest priority): next edge gives out_valid=0 and FSM=IDLE, and any concurrent accept is discarded.
//    out_* data is not required to clear.
//  - Async reset mid-MUL: immediate abort. No partial result is ever presented.
// CONFIGURATION
//  EXE_MUL_EN defined: MUL (op 8) is implemented as above, with the BUSY/DONE FSM and iteration regs present.
//  EXE_MUL_EN undefined: op 8 is illegal (1-cycle, result 0, illegal=1).
//    The FSM stays in IDLE and no multiplier logic is synthesised.
// TESTING (ARQ=16)
//  1. ADD 0xFFFF+0x0001, out_ready=1 -> next cycle out_valid=1, result 0x0000, flags=3'b011.
//  2. SUB 3-5 -> result 0xFFFE, carry=1. SHR 0x8000 by src2=0x0013 -> shift 3, result 0x1000.
//  3. MUL 300*200 (EXE_MUL_EN) -> in_ready=0 for 17 cycles, then out_valid=1, result 0xEA60.
//     Without EXE_MUL_EN -> result 0, flags=3'b101 after 1 cycle.
//  4. Back-to-back ADDs with out_ready=0 -> 2nd op stalls (in_ready=0), out_* held.
//     out_ready=1 -> 2nd accepted on the consuming edge, out_valid stays 1.
//  5. flush during MUL BUSY (cycle 5) -> out_valid stays 0, in_ready=1 next cycle, later ADD 1+1=2 correct.
//  6. rst=0 mid-MUL -> all outputs 0 immediately. After release, op 0xF -> illegal=1, out_wb_en=0.

Source files
------------

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with valid/ready handshakes, ALU and EX/MEM output register.
// Define EXE_MUL_EN to build the iterative shift-add multiplier (op 8); otherwise op 8 is illegal.
module exe_stage_mc #(
  parameter int ARQ  = 16,
  parameter int REGW = 4,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [ARQ-1:0]  in_src1,
  input  logic [ARQ-1:0]  in_src2,
  input  logic [ARQ-1:0]  in_src3,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_wb_en,
  input  logic            in_rd_mem,
  input  logic            in_wr_mem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ARQ-1:0]  out_result,
  output logic [ARQ-1:0]  out_src3,
  output logic [REGW-1:0] out_rd,
  output logic            out_wb_en,
  output logic            out_rd_mem,
  output logic            out_wr_mem,
  output logic [2:0]      out_flags
);
  localparam int SHW = $clog2(ARQ);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q, state_d;
  logic            ov_q, ov_d;
  logic [ARQ-1:0]  res_q, res_d, src3_q, src3_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [2:0]      ctl_q, ctl_d, flags_q, flags_d;
  logic [ARQ:0]    sum;
  logic [ARQ-1:0]  alu_r;
  logic            alu_c, alu_ill, is_mul, slot_free, take;
`ifdef EXE_MUL_EN
  logic [ARQ-1:0]  ma_q, ma_d, mb_q, mb_d, acc_q, acc_d, ms3_q, ms3_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [REGW-1:0] mrd_q, mrd_d;
  logic [2:0]      mctl_q, mctl_d;
  assign is_mul = in_op == OPW'(8);
`else
  assign is_mul = 1'b0;
`endif
  assign slot_free  = !ov_q || out_ready;
  assign in_ready   = (state_q == IDLE) && slot_free && rst;
  assign take       = in_valid && in_ready;
  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_src3   = src3_q;
  assign out_rd     = rd_q;
  assign {out_wb_en, out_rd_mem, out_wr_mem} = ctl_q;
  assign out_flags  = flags_q;
  always_comb begin
    sum     = {1'b0, in_src1} + {1'b0, in_src2};
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    case (in_op)
      OPW'(0): begin alu_r = sum[ARQ-1:0]; alu_c = sum[ARQ]; end
      OPW'(1): begin alu_r = in_src1 - in_src2; alu_c = in_src1 < in_src2; end
      OPW'(2): alu_r = in_src1 & in_src2;
      OPW'(3): alu_r = in_src1 | in_src2;
      OPW'(4): alu_r = in_src1 ^ in_src2;
      OPW'(5): alu_r = in_src1 << in_src2[SHW-1:0];
      OPW'(6): alu_r = in_src1 >> in_src2[SHW-1:0];
      OPW'(7): alu_r = in_src2;
      default: alu_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ov_d    = ov_q && !out_ready;
    res_d   = res_q;
    src3_d  = src3_q;
    rd_d    = rd_q;
    ctl_d   = ctl_q;
    flags_d = flags_q;
`ifdef EXE_MUL_EN
    ma_d   = ma_q;
    mb_d   = mb_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ms3_d  = ms3_q;
    mrd_d  = mrd_q;
    mctl_d = mctl_q;
`endif
    if (take && !is_mul) begin
      res_d   = alu_r;
      src3_d  = in_src3;
      rd_d    = in_rd;
      ctl_d   = alu_ill ? 3'b000 : {in_wb_en, in_rd_mem, in_wr_mem};
      flags_d = {alu_ill, alu_c, alu_r == '0};
      ov_d    = 1'b1;
    end
`ifdef EXE_MUL_EN
    case (state_q)
      IDLE: if (take && is_mul) begin
        ma_d    = in_src1;
        mb_d    = in_src2;
        acc_d   = '0;
        cnt_d   = SHW'(ARQ - 1);
        ms3_d   = in_src3;
        mrd_d   = in_rd;
        mctl_d  = {in_wb_en, in_rd_mem, in_wr_mem};
        state_d = BUSY;
      end
      BUSY: begin
        acc_d   = mb_q[0] ? acc_q + ma_q : acc_q;
        ma_d    = ma_q << 1;
        mb_d    = mb_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? DONE : BUSY;
      end
      DONE: if (slot_free) begin
        res_d   = acc_q;
        src3_d  = ms3_q;
        rd_d    = mrd_q;
        ctl_d   = mctl_q;
        flags_d = {2'b00, acc_q == '0};
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`endif
    if (flush) begin
      ov_d    = 1'b0;
      state_d = IDLE;
    end
  end
  // async reset aborts any multiply in flight; no partial result survives it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      res_q   <= '0;
      src3_q  <= '0;
      rd_q    <= '0;
      ctl_q   <= '0;
      flags_q <= '0;
`ifdef EXE_MUL_EN
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ms3_q   <= '0;
      mrd_q   <= '0;
      mctl_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      src3_q  <= src3_d;
      rd_q    <= rd_d;
      ctl_q   <= ctl_d;
      flags_q <= flags_d;
`ifdef EXE_MUL_EN
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ms3_q   <= ms3_d;
      mrd_q   <= mrd_d;
      mctl_q  <= mctl_d;
`endif
    end
  end
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: random + directed stimulus for exe_stage_mc, scoreboard checked against an arithmetic model.
module tb_exe_stage_mc;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_wb_en, out_rd_mem, out_wr_mem;
  logic        in_wb_en = 1'b0, in_rd_mem = 1'b0, in_wr_mem = 1'b0;
  logic [3:0]  in_op = '0, in_rd = '0, out_rd;
  logic [15:0] in_src1 = '0, in_src2 = '0, in_src3 = '0, out_result, out_src3;
  logic [2:0]  out_flags;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] src3;
    logic [3:0]  rd;
    logic [2:0]  ctl;
    logic [2:0]  flags;
  } exp_t;
  exp_t q[$];

  exe_stage_mc dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_src3(in_src3), .in_rd(in_rd),
    .in_wb_en(in_wb_en), .in_rd_mem(in_rd_mem), .in_wr_mem(in_wr_mem),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_src3(out_src3),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_rd_mem(out_rd_mem), .out_wr_mem(out_wr_mem),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, b, c,
                                 input logic [3:0] rd, input logic [2:0] ctl);
    int unsigned ua = a, ub = b, r = 0;
    logic cy = 1'b0, ill = 1'b0;
    exp_t e;
    case (op)
      4'd0: begin r = ua + ub; cy = r > 32'hFFFF; end
      4'd1: begin r = ua - ub; cy = ua < ub; end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ua << (ub % 16);
      4'd6: r = ua >> (ub % 16);
      4'd7: r = ub;
`ifdef EXE_MUL_EN
      4'd8: r = ua * ub;
`endif
      default: ill = 1'b1;
    endcase
    e.res   = ill ? 16'h0 : r[15:0];
    e.src3  = c;
    e.rd    = rd;
    e.ctl   = ill ? 3'b000 : ctl;
    e.flags = {ill, cy, e.res == 16'h0};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, b, c, input logic [3:0] rd,
                       input logic [2:0] ctl);
    in_op = op; in_src1 = a; in_src2 = b; in_src3 = c; in_rd = rd;
    {in_wb_en, in_rd_mem, in_wr_mem} = ctl;
  endtask

  // called just after a falling edge; returns at the falling edge after the accepting edge
  task automatic send(input logic [3:0] op, input logic [15:0] a, b, c, input logic [3:0] rd,
                      input logic [2:0] ctl);
    int n = 0;
    drive(op, a, b, c, rd, ctl);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk("send_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready) q.push_back(model(op, a, b, c, rd, ctl));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // monitor: compares the presented entry to the scoreboard head, pops on consume
  initial begin
    bit hold = 0;
    int idle = 0;
    exp_t act;
    forever begin
      @(negedge clk); #2;
      if (!rst || flush) begin
        hold = 0; idle = 0;
      end else begin
        if (hold) chk("hold_valid", {31'b0, out_valid}, 32'd1);
        if (out_valid) begin
          idle = 0;
          act = '{out_result, out_src3, out_rd, {out_wb_en, out_rd_mem, out_wr_mem}, out_flags};
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious: got res=%h flags=%b expected no output", out_result, out_flags);
          end else begin
            checks++;
            if (act !== q[0]) begin
              errors++;
              $display("FAIL result: got res=%h s3=%h rd=%h ctl=%b fl=%b expected res=%h s3=%h rd=%h ctl=%b fl=%b",
                       act.res, act.src3, act.rd, act.ctl, act.flags,
                       q[0].res, q[0].src3, q[0].rd, q[0].ctl, q[0].flags);
            end
            if (out_ready) void'(q.pop_front());
          end
        end else if (q.size() > 0) begin
          idle++;
          if (idle > 40) begin
            checks++; errors++;
            $display("FAIL timeout: got no out_valid expected res=%h", q[0].res);
            void'(q.pop_front());
            idle = 0;
          end
        end
        hold = out_valid && !out_ready;
      end
    end
  end

  initial begin
    int n;
    logic [15:0] b_val;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_result", {16'b0, out_result}, 32'd0);
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    // ADD overflow: latency 1, flags carry+zero
    send(4'd0, 16'hFFFF, 16'h0001, 16'h1234, 4'd3, 3'b100);
    chk("add_lat1", {31'b0, out_valid}, 32'd1);
    chk("add_flags", {29'b0, out_flags}, 32'b011);
    send(4'd1, 16'd3, 16'd5, 16'h0, 4'd1, 3'b100);
    send(4'd6, 16'h8000, 16'h0013, 16'h0, 4'd2, 3'b100);
    send(4'd5, 16'h0001, 16'h000F, 16'h5, 4'd2, 3'b001);
    // multiply 300*200
    send(4'd8, 16'd300, 16'd200, 16'hBEEF, 4'd7, 3'b110);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
`ifdef EXE_MUL_EN
    chk("mul_latency", n, 32'd17);
`else
    chk("mul_latency", n, 32'd0);
    chk("mul_ill_flags", {29'b0, out_flags}, 32'b101);
`endif
    // back-to-back with stalled output
    @(negedge clk); out_ready = 1'b0;
    send(4'd0, 16'd10, 16'd20, 16'h0, 4'd4, 3'b100);
    drive(4'd0, 16'd7, 16'd8, 16'h9, 4'd5, 3'b100);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("consume_accept", {31'b0, in_ready}, 32'd1);
    if (in_ready) q.push_back(model(4'd0, 16'd7, 16'd8, 16'h9, 4'd5, 3'b100));
    @(negedge clk); in_valid = 1'b0;
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_result", {16'b0, out_result}, 32'd15);
    // flush during a multiply
    @(negedge clk);
    send(4'd8, 16'd1234, 16'd77, 16'h0, 4'd1, 3'b100);
    repeat (4) @(negedge clk);
    flush = 1'b1; out_ready = 1'b0; q.delete();
    @(negedge clk); flush = 1'b0; out_ready = 1'b1;
    #1 chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    send(4'd0, 16'd1, 16'd1, 16'h0, 4'd6, 3'b100);
    // flush discards a concurrent accept
    drive(4'd3, 16'h00F0, 16'h000F, 16'h0, 4'd2, 3'b100);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0; q.delete();
    @(negedge clk); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #1 chk("flush_accept", {31'b0, out_valid}, 32'd0);
    // async reset mid-multiply
    @(negedge clk);
    send(4'd8, 16'd300, 16'd200, 16'h0, 4'd1, 3'b100);
    repeat (3) @(negedge clk);
    #3 rst = 1'b0; q.delete();
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", {16'b0, out_result}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd0);
    chk("arst_ctl", {29'b0, out_wb_en, out_rd_mem, out_wr_mem}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_partial", {31'b0, out_valid}, 32'd0);
    send(4'hF, 16'd9, 16'd9, 16'h0, 4'd3, 3'b111);
    chk("illegal_flag", {31'b0, out_flags[2]}, 32'd1);
    chk("illegal_wb", {31'b0, out_wb_en}, 32'd0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      flush = ($urandom % 60) == 0;
      out_ready = flush ? 1'b0 : (($urandom % 4) != 0);
      in_valid = ($urandom % 3) != 0;
      b_val = ($urandom % 3 == 0) ? 16'($urandom % 20) : 16'($urandom);
      drive((($urandom % 8) == 0) ? 4'($urandom % 16) : 4'($urandom % 9),
            16'($urandom), b_val, 16'($urandom), 4'($urandom), 3'($urandom));
      #1;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_op, in_src1, in_src2, in_src3, in_rd,
                                                       {in_wb_en, in_rd_mem, in_wr_mem}));
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("drain", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
